// File: rtl/osd_wb_pkg.sv
// Wishbone registered-feedback encodings shared by the OSD bus adapters,
// plus the MAM-to-Wishbone adapter state type and a CTI helper.
package osd_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_BUS,
        ST_RD_BUS,
        ST_RD_HOLD
    } mam_wb_state_t;

    // CTI for the beat about to be issued; remaining counts this beat.
    function automatic logic [2:0] beat_cti(input logic burst, input logic [13:0] remaining);
        if (!burst) return CTI_CLASSIC;
        return (remaining == 14'd1) ? CTI_EOB : CTI_INCR;
    endfunction

endpackage

// File: rtl/mam_wb_adapter_if.sv
// MAM request/data channels and the Wishbone B3 master bus.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
interface mam_if #(parameter int DATA_WIDTH = 16, parameter int ADDR_WIDTH = 32);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_rw;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic                    req_burst;
    logic [13:0]             req_beats;
    logic                    write_valid;
    logic                    write_ready;
    logic [DATA_WIDTH-1:0]   write_data;
    logic [DATA_WIDTH/8-1:0] write_strb;
    logic                    read_valid;
    logic                    read_ready;
    logic [DATA_WIDTH-1:0]   read_data;

    modport master (
        output req_valid, req_rw, req_addr, req_burst, req_beats,
        output write_valid, write_data, write_strb, read_ready,
        input  req_ready, write_ready, read_valid, read_data
    );
    modport slave (
        input  req_valid, req_rw, req_addr, req_burst, req_beats,
        input  write_valid, write_data, write_strb, read_ready,
        output req_ready, write_ready, read_valid, read_data
    );
endinterface

interface wb_if #(parameter int DATA_WIDTH = 16, parameter int ADDR_WIDTH = 32);
    logic                    wb_cyc_o;
    logic                    wb_stb_o;
    logic                    wb_we_o;
    logic [ADDR_WIDTH-1:0]   wb_adr_o;
    logic [DATA_WIDTH-1:0]   wb_dat_o;
    logic [DATA_WIDTH/8-1:0] wb_sel_o;
    logic [2:0]              wb_cti_o;
    logic [1:0]              wb_bte_o;
    logic                    wb_ack_i;
    logic                    wb_err_i;
    logic [DATA_WIDTH-1:0]   wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_bte_o,
        input  wb_ack_i, wb_err_i, wb_dat_i
    );
    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_bte_o,
        output wb_ack_i, wb_err_i, wb_dat_i
    );
endinterface

// File: rtl/mam_wb_adapter.sv
// Bridges MAM single/burst requests onto a Wishbone master bus, one beat at a time,
// with all bus outputs and read data registered.
module mam_wb_adapter
    import osd_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mam_if.slave          mam,
    wb_if.master          wb,
    output mam_wb_state_t dbg_state
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(STRB_WIDTH);

    mam_wb_state_t           state_q;
    logic [13:0]             beats_q;
    logic                    burst_q;
    logic                    cyc_q, stb_q, we_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [STRB_WIDTH-1:0]   sel_q;
    logic [2:0]              cti_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic        beat_done;
    logic [13:0] req_count;

    // err wins over ack; responses while stb is low never count as a beat.
    assign beat_done = stb_q & (wb.wb_ack_i | wb.wb_err_i);
    assign req_count = (!mam.req_burst || mam.req_beats == 14'd0) ? 14'd1 : mam.req_beats;

    assign mam.req_ready   = (state_q == ST_IDLE);
    assign mam.write_ready = (state_q == ST_WR_DATA);
    assign mam.read_valid  = (state_q == ST_RD_HOLD);
    assign mam.read_data   = rdata_q;

    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = stb_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_cti_o = cti_q;
    assign wb.wb_bte_o = BTE_LINEAR;

    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beats_q <= '0;
            burst_q <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            cti_q   <= CTI_CLASSIC;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mam.req_valid) begin
                        burst_q <= mam.req_burst;
                        adr_q   <= mam.req_addr;
                        beats_q <= req_count;
                        if (mam.req_rw) begin
                            state_q <= ST_WR_DATA;
                        end else begin
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            we_q    <= 1'b0;
                            sel_q   <= '1;
                            cti_q   <= beat_cti(mam.req_burst, req_count);
                            state_q <= ST_RD_BUS;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (mam.write_valid) begin
                        dat_q   <= mam.write_data;
                        sel_q   <= burst_q ? '1 : mam.write_strb;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= 1'b1;
                        cti_q   <= beat_cti(burst_q, beats_q);
                        state_q <= ST_WR_BUS;
                    end
                end
                ST_WR_BUS: begin
                    if (beat_done) begin
                        stb_q   <= 1'b0;
                        beats_q <= beats_q - 14'd1;
                        adr_q   <= adr_q + ADDR_STEP;
                        if (beats_q == 14'd1) begin
                            cyc_q   <= 1'b0;
                            we_q    <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_WR_DATA;
                        end
                    end
                end
                ST_RD_BUS: begin
                    if (beat_done) begin
                        rdata_q <= wb.wb_err_i ? '0 : wb.wb_dat_i;
                        stb_q   <= 1'b0;
                        beats_q <= beats_q - 14'd1;
                        adr_q   <= adr_q + ADDR_STEP;
                        state_q <= ST_RD_HOLD;
                    end
                end
                ST_RD_HOLD: begin
                    // beats_q already counts the beat just delivered.
                    if (mam.read_ready) begin
                        if (beats_q == 14'd0) begin
                            cyc_q   <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            stb_q   <= 1'b1;
                            cti_q   <= beat_cti(burst_q, beats_q);
                            state_q <= ST_RD_BUS;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mam_wb_adapter.sv
// Directed bench for mam_wb_adapter (16-bit data, 16-bit addresses).
module tb_mam_wb_adapter;
    import osd_wb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mam_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) mam ();
    wb_if  #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) wb ();
    mam_wb_state_t dbg_state;

    mam_wb_adapter #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .mam(mam), .wb(wb), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    // {cyc, stb, we, adr, sel, cti}
    logic [23:0] bus_vec;
    assign bus_vec = {wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, wb.wb_adr_o, wb.wb_sel_o, wb.wb_cti_o};

    function automatic logic [23:0] bv(input logic [2:0] cse, input logic [15:0] adr,
                                       input logic [1:0] sel, input logic [2:0] cti);
        return {cse, adr, sel, cti};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mam.req_valid = 0; mam.req_rw = 0; mam.req_addr = '0; mam.req_burst = 0; mam.req_beats = '0;
        mam.write_valid = 0; mam.write_data = '0; mam.write_strb = '0; mam.read_ready = 1;
        wb.wb_ack_i = 0; wb.wb_err_i = 0; wb.wb_dat_i = '0;
    endtask

    task automatic request(input logic rw, input logic [15:0] addr, input logic burst, input logic [13:0] beats);
        mam.req_valid = 1; mam.req_rw = rw; mam.req_addr = addr; mam.req_burst = burst; mam.req_beats = beats;
        tick();
        mam.req_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        repeat (3) tick();
        checks++; if (bus_vec !== 24'h0) begin errors++; $display("FAIL reset_bus got %h exp %h", bus_vec, 24'h0); end
        checks++; if ({wb.wb_dat_o, mam.read_data} !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp %h", {wb.wb_dat_o, mam.read_data}, 32'h0); end
        checks++; if ({wb.wb_bte_o, mam.read_valid} !== 3'b000) begin errors++; $display("FAIL reset_bte_rv got %b exp %b", {wb.wb_bte_o, mam.read_valid}, 3'b000); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE); end
        rst = 0;
        tick();
        checks++; if ({mam.req_ready, mam.write_ready} !== 2'b10) begin errors++; $display("FAIL reset_ready got %b exp %b", {mam.req_ready, mam.write_ready}, 2'b10); end
    endtask

    task automatic test_single_write();
        request(1'b1, 16'h1000, 1'b0, 14'd5);
        checks++; if ({mam.write_ready, wb.wb_cyc_o, wb.wb_stb_o} !== 3'b100) begin errors++; $display("FAIL sw_wr_data got %b exp %b", {mam.write_ready, wb.wb_cyc_o, wb.wb_stb_o}, 3'b100); end
        mam.write_valid = 1; mam.write_data = 16'hBEEF; mam.write_strb = 2'b01;
        tick();
        mam.write_valid = 0;
        checks++; if (bus_vec !== bv(3'b111, 16'h1000, 2'b01, 3'b000)) begin errors++; $display("FAIL sw_bus got %h exp %h", bus_vec, bv(3'b111, 16'h1000, 2'b01, 3'b000)); end
        checks++; if (wb.wb_dat_o !== 16'hBEEF) begin errors++; $display("FAIL sw_dat got %h exp %h", wb.wb_dat_o, 16'hBEEF); end
        tick();
        tick();
        checks++; if (bus_vec !== bv(3'b111, 16'h1000, 2'b01, 3'b000)) begin errors++; $display("FAIL sw_wait got %h exp %h", bus_vec, bv(3'b111, 16'h1000, 2'b01, 3'b000)); end
        wb.wb_ack_i = 1;
        tick();
        wb.wb_ack_i = 0;
        checks++; if ({wb.wb_cyc_o, wb.wb_stb_o, mam.req_ready} !== 3'b001) begin errors++; $display("FAIL sw_done got %b exp %b", {wb.wb_cyc_o, wb.wb_stb_o, mam.req_ready}, 3'b001); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL sw_state got %0d exp %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_burst_read();
        logic cyc_gap;
        logic [15:0] a;
        logic [2:0] cti;
        cyc_gap = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back(16'(16'h0011 * (i + 1)));
        request(1'b0, 16'h2000, 1'b1, 14'd4);
        for (int i = 0; i < 4; i++) begin
            a = 16'h2000 + 16'(2 * i);
            cti = (i == 3) ? 3'b111 : 3'b010;
            checks++; if (bus_vec !== bv(3'b110, a, 2'b11, cti)) begin errors++; $display("FAIL br_bus%0d got %h exp %h", i, bus_vec, bv(3'b110, a, 2'b11, cti)); end
            wb.wb_dat_i = exp_q[0]; wb.wb_ack_i = 1;
            tick();
            wb.wb_ack_i = 0;
            if (!wb.wb_cyc_o) cyc_gap = 1;
            checks++; if ({mam.read_valid, wb.wb_stb_o, wb.wb_cyc_o} !== 3'b101) begin errors++; $display("FAIL br_hold%0d got %b exp %b", i, {mam.read_valid, wb.wb_stb_o, wb.wb_cyc_o}, 3'b101); end
            checks++; if (mam.read_data !== exp_q[0]) begin errors++; $display("FAIL br_data%0d got %h exp %h", i, mam.read_data, exp_q[0]); end
            void'(exp_q.pop_front());
            tick();
            if (i < 3 && !wb.wb_cyc_o) cyc_gap = 1;
        end
        checks++; if (cyc_gap !== 1'b0) begin errors++; $display("FAIL br_cyc_gap got %b exp %b", cyc_gap, 1'b0); end
        checks++; if ({wb.wb_cyc_o, wb.wb_stb_o, mam.req_ready} !== 3'b001) begin errors++; $display("FAIL br_done got %b exp %b", {wb.wb_cyc_o, wb.wb_stb_o, mam.req_ready}, 3'b001); end
    endtask

    task automatic test_backpressure();
        request(1'b0, 16'h3000, 1'b1, 14'd3);
        wb.wb_dat_i = 16'h0101; wb.wb_ack_i = 1;
        tick();
        wb.wb_ack_i = 0;
        checks++; if (mam.read_data !== 16'h0101) begin errors++; $display("FAIL bp_data1 got %h exp %h", mam.read_data, 16'h0101); end
        tick();
        checks++; if (bus_vec !== bv(3'b110, 16'h3002, 2'b11, 3'b010)) begin errors++; $display("FAIL bp_bus2 got %h exp %h", bus_vec, bv(3'b110, 16'h3002, 2'b11, 3'b010)); end
        wb.wb_dat_i = 16'h0202; wb.wb_ack_i = 1; mam.read_ready = 0;
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++; if ({mam.read_valid, wb.wb_cyc_o, wb.wb_stb_o} !== 3'b110) begin errors++; $display("FAIL bp_hold%0d got %b exp %b", k, {mam.read_valid, wb.wb_cyc_o, wb.wb_stb_o}, 3'b110); end
            checks++; if (mam.read_data !== 16'h0202) begin errors++; $display("FAIL bp_stable%0d got %h exp %h", k, mam.read_data, 16'h0202); end
            wb.wb_ack_i = 1; wb.wb_dat_i = 16'hAAAA;
            tick();
        end
        checks++; if (mam.read_data !== 16'h0202) begin errors++; $display("FAIL bp_stray_ack got %h exp %h", mam.read_data, 16'h0202); end
        wb.wb_ack_i = 0; mam.read_ready = 1;
        tick();
        checks++; if (bus_vec !== bv(3'b110, 16'h3004, 2'b11, 3'b111)) begin errors++; $display("FAIL bp_bus3 got %h exp %h", bus_vec, bv(3'b110, 16'h3004, 2'b11, 3'b111)); end
        wb.wb_dat_i = 16'h0303; wb.wb_ack_i = 1;
        tick();
        wb.wb_ack_i = 0;
        checks++; if (mam.read_data !== 16'h0303) begin errors++; $display("FAIL bp_data3 got %h exp %h", mam.read_data, 16'h0303); end
        tick();
        checks++; if ({wb.wb_cyc_o, wb.wb_stb_o, mam.req_ready} !== 3'b001) begin errors++; $display("FAIL bp_done got %b exp %b", {wb.wb_cyc_o, wb.wb_stb_o, mam.req_ready}, 3'b001); end
    endtask

    task automatic test_error();
        request(1'b0, 16'h4000, 1'b1, 14'd2);
        checks++; if (bus_vec !== bv(3'b110, 16'h4000, 2'b11, 3'b010)) begin errors++; $display("FAIL er_bus1 got %h exp %h", bus_vec, bv(3'b110, 16'h4000, 2'b11, 3'b010)); end
        wb.wb_dat_i = 16'hDEAD; wb.wb_ack_i = 1; wb.wb_err_i = 1;
        tick();
        wb.wb_ack_i = 0; wb.wb_err_i = 0;
        checks++; if ({mam.read_valid, mam.read_data} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL er_data1 got %h exp %h", {mam.read_valid, mam.read_data}, {1'b1, 16'h0000}); end
        tick();
        checks++; if (bus_vec !== bv(3'b110, 16'h4002, 2'b11, 3'b111)) begin errors++; $display("FAIL er_bus2 got %h exp %h", bus_vec, bv(3'b110, 16'h4002, 2'b11, 3'b111)); end
        wb.wb_dat_i = 16'h5555; wb.wb_ack_i = 1;
        tick();
        wb.wb_ack_i = 0;
        checks++; if (mam.read_data !== 16'h5555) begin errors++; $display("FAIL er_data2 got %h exp %h", mam.read_data, 16'h5555); end
        tick();
        checks++; if ({wb.wb_cyc_o, wb.wb_stb_o, mam.req_ready} !== 3'b001) begin errors++; $display("FAIL er_done got %b exp %b", {wb.wb_cyc_o, wb.wb_stb_o, mam.req_ready}, 3'b001); end
    endtask

    task automatic test_addr_wrap();
        request(1'b1, 16'hFFFE, 1'b1, 14'd2);
        mam.write_valid = 1; mam.write_data = 16'h1111; mam.write_strb = 2'b01;
        tick();
        mam.write_valid = 0;
        checks++; if (bus_vec !== bv(3'b111, 16'hFFFE, 2'b11, 3'b010)) begin errors++; $display("FAIL wr_bus1 got %h exp %h", bus_vec, bv(3'b111, 16'hFFFE, 2'b11, 3'b010)); end
        wb.wb_ack_i = 1;
        tick();
        wb.wb_ack_i = 0;
        checks++; if ({wb.wb_cyc_o, wb.wb_stb_o, mam.write_ready} !== 3'b101) begin errors++; $display("FAIL wr_between got %b exp %b", {wb.wb_cyc_o, wb.wb_stb_o, mam.write_ready}, 3'b101); end
        mam.write_valid = 1; mam.write_data = 16'h2222; mam.write_strb = 2'b00;
        tick();
        mam.write_valid = 0;
        checks++; if (bus_vec !== bv(3'b111, 16'h0000, 2'b11, 3'b111)) begin errors++; $display("FAIL wr_bus2 got %h exp %h", bus_vec, bv(3'b111, 16'h0000, 2'b11, 3'b111)); end
        checks++; if (wb.wb_dat_o !== 16'h2222) begin errors++; $display("FAIL wr_dat2 got %h exp %h", wb.wb_dat_o, 16'h2222); end
        wb.wb_ack_i = 1;
        tick();
        wb.wb_ack_i = 0;
        checks++; if ({wb.wb_cyc_o, wb.wb_stb_o, mam.req_ready} !== 3'b001) begin errors++; $display("FAIL wr_done got %b exp %b", {wb.wb_cyc_o, wb.wb_stb_o, mam.req_ready}, 3'b001); end
    endtask

    task automatic test_reset_mid_burst();
        request(1'b1, 16'h5000, 1'b1, 14'd8);
        for (int b = 0; b < 3; b++) begin
            mam.write_valid = 1; mam.write_data = 16'(b + 1);
            tick();
            mam.write_valid = 0;
            if (b < 2) begin
                wb.wb_ack_i = 1;
                tick();
                wb.wb_ack_i = 0;
            end
        end
        checks++; if (bus_vec !== bv(3'b111, 16'h5004, 2'b11, 3'b010)) begin errors++; $display("FAIL rm_beat3 got %h exp %h", bus_vec, bv(3'b111, 16'h5004, 2'b11, 3'b010)); end
        rst = 1;
        tick();
        rst = 0;
        checks++; if (bus_vec !== 24'h0) begin errors++; $display("FAIL rm_bus got %h exp %h", bus_vec, 24'h0); end
        checks++; if ({mam.req_ready, mam.write_ready, mam.read_valid} !== 3'b100) begin errors++; $display("FAIL rm_ready got %b exp %b", {mam.req_ready, mam.write_ready, mam.read_valid}, 3'b100); end
        request(1'b0, 16'h6000, 1'b0, 14'd0);
        checks++; if (bus_vec !== bv(3'b110, 16'h6000, 2'b11, 3'b000)) begin errors++; $display("FAIL rm_rd_bus got %h exp %h", bus_vec, bv(3'b110, 16'h6000, 2'b11, 3'b000)); end
        wb.wb_dat_i = 16'h1234; wb.wb_ack_i = 1;
        tick();
        wb.wb_ack_i = 0;
        checks++; if ({mam.read_valid, mam.read_data} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL rm_rd_data got %h exp %h", {mam.read_valid, mam.read_data}, {1'b1, 16'h1234}); end
        tick();
        checks++; if ({wb.wb_cyc_o, wb.wb_stb_o, mam.req_ready} !== 3'b001) begin errors++; $display("FAIL rm_done got %b exp %b", {wb.wb_cyc_o, wb.wb_stb_o, mam.req_ready}, 3'b001); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_burst_read();
        test_backpressure();
        test_error();
        test_addr_wrap();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
